// File: rtl/ycr1_timer_arb_pkg.sv
// ycr1_timer_arb_pkg: shared types for the timer dmem arbiter, plus the memif codes it speaks
`ifndef YCR1_DMEM_AWIDTH
`define YCR1_DMEM_AWIDTH 32
`endif
`ifndef YCR1_DMEM_DWIDTH
`define YCR1_DMEM_DWIDTH 32
`endif
package ycr1_timer_arb_pkg;
    typedef enum logic {
        YCR1_MEM_CMD_RD = 1'b0,
        YCR1_MEM_CMD_WR = 1'b1
    } type_ycr1_mem_cmd_e;
    typedef enum logic [1:0] {
        YCR1_MEM_WIDTH_BYTE  = 2'b00,
        YCR1_MEM_WIDTH_HWORD = 2'b01,
        YCR1_MEM_WIDTH_WORD  = 2'b10,
        YCR1_MEM_WIDTH_ERROR = 2'b11
    } type_ycr1_mem_width_e;
    typedef enum logic [1:0] {
        YCR1_MEM_RESP_NOTRDY = 2'b00,
        YCR1_MEM_RESP_RDY_OK = 2'b01,
        YCR1_MEM_RESP_RDY_ER = 2'b10
    } type_ycr1_mem_resp_e;
    typedef enum logic [1:0] {IDLE, REQ, RESP} type_ycr1_tarb_state_e;
    typedef logic type_ycr1_tarb_port_t;
endpackage

// File: rtl/ycr1_rr_arb2.sv
// ycr1_rr_arb2: combinational 2-way round-robin picker; ptr breaks ties
module ycr1_rr_arb2
    import ycr1_timer_arb_pkg::*;
(
    input  logic                 [1:0] req,
    input  type_ycr1_tarb_port_t       ptr,
    output logic                       gnt_vld,
    output type_ycr1_tarb_port_t       gnt_idx
);
    assign gnt_vld = |req;
    assign gnt_idx = (req == 2'b11) ? ptr : req[1];
endmodule

// File: rtl/ycr1_timer_dmem_arb.sv
// ycr1_timer_dmem_arb: serialises two dmem masters onto the timer slave port
// Optional RESP timeout returning RDY_ER: YCR1_TIMER_ARB_TIMEOUT_EN
`ifndef YCR1_DMEM_AWIDTH
`define YCR1_DMEM_AWIDTH 32
`endif
`ifndef YCR1_DMEM_DWIDTH
`define YCR1_DMEM_DWIDTH 32
`endif
module ycr1_timer_dmem_arb
    import ycr1_timer_arb_pkg::*;
#(
    parameter int TMO_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         p0_req,
    input  logic                         p0_cmd,
    input  logic [1:0]                   p0_width,
    input  logic [`YCR1_DMEM_AWIDTH-1:0] p0_addr,
    input  logic [`YCR1_DMEM_DWIDTH-1:0] p0_wdata,
    output logic                         p0_req_ack,
    output logic [`YCR1_DMEM_DWIDTH-1:0] p0_rdata,
    output logic [1:0]                   p0_resp,
    input  logic                         p1_req,
    input  logic                         p1_cmd,
    input  logic [1:0]                   p1_width,
    input  logic [`YCR1_DMEM_AWIDTH-1:0] p1_addr,
    input  logic [`YCR1_DMEM_DWIDTH-1:0] p1_wdata,
    output logic                         p1_req_ack,
    output logic [`YCR1_DMEM_DWIDTH-1:0] p1_rdata,
    output logic [1:0]                   p1_resp,
    output logic                         t_req,
    output logic                         t_cmd,
    output logic [1:0]                   t_width,
    output logic [`YCR1_DMEM_AWIDTH-1:0] t_addr,
    output logic [`YCR1_DMEM_DWIDTH-1:0] t_wdata,
    input  logic                         t_req_ack,
    input  logic [`YCR1_DMEM_DWIDTH-1:0] t_rdata,
    input  logic [1:0]                   t_resp
);
    if (TMO_CYCLES < 2 || TMO_CYCLES > 1023) begin : g_tmo_range
        $error("ycr1_timer_dmem_arb: TMO_CYCLES must be within 2..1023");
    end
    type_ycr1_tarb_state_e        state_q, state_d;
    type_ycr1_tarb_port_t         owner_q, rr_ptr_q, gnt_idx;
    logic                         gnt_vld, grant, done, resp_rdy, tmo;
    logic [1:0]                   done_resp;
    logic [`YCR1_DMEM_DWIDTH-1:0] done_rdata;
    ycr1_rr_arb2 u_rr (
        .req     ({p1_req, p0_req}),
        .ptr     (rr_ptr_q),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );
    assign t_req      = (state_q == REQ);
    assign resp_rdy   = (t_resp != YCR1_MEM_RESP_NOTRDY);
    assign done_resp  = resp_rdy ? t_resp : YCR1_MEM_RESP_RDY_ER;
    assign done_rdata = resp_rdy ? t_rdata : '0;
`ifdef YCR1_TIMER_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYCLES + 1);
    logic [TMO_W-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= (state_q == RESP) ? cnt_q + 1'b1 : '0;
    end
    // Fires on the cycle whose edge brings the count to TMO_CYCLES; a real response still wins
    assign tmo = (cnt_q == TMO_W'(TMO_CYCLES - 1));
`else
    assign tmo = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                grant   = gnt_vld;
                state_d = gnt_vld ? REQ : IDLE;
            end
            REQ:  state_d = t_req_ack ? RESP : REQ;
            RESP: begin
                done    = resp_rdy | tmo;
                state_d = done ? IDLE : RESP;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            rr_ptr_q   <= 1'b0;
            p0_req_ack <= 1'b0;
            p1_req_ack <= 1'b0;
            p0_resp    <= YCR1_MEM_RESP_NOTRDY;
            p1_resp    <= YCR1_MEM_RESP_NOTRDY;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
            t_cmd      <= 1'b0;
            t_width    <= '0;
            t_addr     <= '0;
            t_wdata    <= '0;
        end else begin
            state_q    <= state_d;
            p0_req_ack <= grant & ~gnt_idx;
            p1_req_ack <= grant & gnt_idx;
            p0_resp    <= (done & ~owner_q) ? done_resp : YCR1_MEM_RESP_NOTRDY;
            p1_resp    <= (done & owner_q) ? done_resp : YCR1_MEM_RESP_NOTRDY;
            p0_rdata   <= (done & ~owner_q) ? done_rdata : '0;
            p1_rdata   <= (done & owner_q) ? done_rdata : '0;
            if (grant) begin
                owner_q  <= gnt_idx;
                rr_ptr_q <= ~gnt_idx;
                t_cmd    <= gnt_idx ? p1_cmd : p0_cmd;
                t_width  <= gnt_idx ? p1_width : p0_width;
                t_addr   <= gnt_idx ? p1_addr : p0_addr;
                t_wdata  <= gnt_idx ? p1_wdata : p0_wdata;
            end
        end
    end
endmodule

// File: tb/tb_ycr1_timer_dmem_arb.sv
// tb_ycr1_timer_dmem_arb: directed bench with a small registered timer model behind the arbiter
`ifndef YCR1_DMEM_AWIDTH
`define YCR1_DMEM_AWIDTH 32
`endif
`ifndef YCR1_DMEM_DWIDTH
`define YCR1_DMEM_DWIDTH 32
`endif
module tb_ycr1_timer_dmem_arb;
    import ycr1_timer_arb_pkg::*;
    localparam logic [31:0] NR = 32'(YCR1_MEM_RESP_NOTRDY);
    localparam logic [31:0] OK = 32'(YCR1_MEM_RESP_RDY_OK);
    localparam logic [31:0] ER = 32'(YCR1_MEM_RESP_RDY_ER);
    localparam logic [1:0]  WORD = YCR1_MEM_WIDTH_WORD;
    localparam logic [1:0]  BYTE = YCR1_MEM_WIDTH_BYTE;
    logic        clk, rst_n;
    logic        p0_req, p0_cmd, p0_req_ack, p1_req, p1_cmd, p1_req_ack;
    logic [1:0]  p0_width, p0_resp, p1_width, p1_resp;
    logic [31:0] p0_addr, p0_wdata, p0_rdata, p1_addr, p1_wdata, p1_rdata;
    logic        t_req, t_cmd, t_req_ack;
    logic [1:0]  t_width, t_resp;
    logic [31:0] t_addr, t_wdata, t_rdata;
    logic        tm_ack, inj;
    logic [1:0]  tm_resp;
    logic [31:0] tm_rdata, tm_cmp;
    int          total = 0;
    int          bad = 0;
    ycr1_timer_dmem_arb #(.TMO_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_cmd(p0_cmd), .p0_width(p0_width), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_req_ack(p0_req_ack), .p0_rdata(p0_rdata), .p0_resp(p0_resp),
        .p1_req(p1_req), .p1_cmd(p1_cmd), .p1_width(p1_width), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_req_ack(p1_req_ack), .p1_rdata(p1_rdata), .p1_resp(p1_resp),
        .t_req(t_req), .t_cmd(t_cmd), .t_width(t_width), .t_addr(t_addr), .t_wdata(t_wdata),
        .t_req_ack(t_req_ack), .t_rdata(t_rdata), .t_resp(t_resp)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    // Timer model: ack one cycle after req, response one cycle after ack; non-WORD stays NOTRDY
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tm_ack   <= 1'b0;
            tm_resp  <= YCR1_MEM_RESP_NOTRDY;
            tm_rdata <= '0;
            tm_cmp   <= '0;
        end else begin
            tm_ack   <= t_req & ~tm_ack;
            tm_resp  <= YCR1_MEM_RESP_NOTRDY;
            tm_rdata <= '0;
            if (tm_ack && t_width == WORD) begin
                tm_resp <= YCR1_MEM_RESP_RDY_OK;
                if (t_cmd == YCR1_MEM_CMD_WR && t_addr == 32'h10) tm_cmp <= t_wdata;
                else if (t_cmd == YCR1_MEM_CMD_RD)
                    tm_rdata <= (t_addr == 32'h08) ? 32'h0000_0123 : (t_addr == 32'h10) ? tm_cmp : 32'h0;
            end
        end
    end
    assign t_req_ack = tm_ack;
    assign t_resp    = inj ? YCR1_MEM_RESP_RDY_OK : tm_resp;
    assign t_rdata   = inj ? 32'h0000_0BAD : tm_rdata;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic chk_ports(input string tag, input logic [31:0] r0, input logic [31:0] d0,
                             input logic [31:0] r1, input logic [31:0] d1);
        chk({tag, "_p0_resp"}, 32'(p0_resp), r0);
        chk({tag, "_p0_rdata"}, p0_rdata, d0);
        chk({tag, "_p1_resp"}, 32'(p1_resp), r1);
        chk({tag, "_p1_rdata"}, p1_rdata, d1);
    endtask
    task automatic chk_acks(input string tag, input logic a0, input logic a1);
        chk({tag, "_p0_ack"}, 32'(p0_req_ack), 32'(a0));
        chk({tag, "_p1_ack"}, 32'(p1_req_ack), 32'(a1));
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end
    initial begin
        rst_n = 1'b0; inj = 1'b0;
        p0_req = 0; p0_cmd = 0; p0_width = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_cmd = 0; p1_width = 0; p1_addr = 0; p1_wdata = 0;
        #3;
        chk_ports("rst", NR, 0, NR, 0);
        chk_acks("rst", 0, 0);
        chk("rst_t_req", 32'(t_req), 0);
        chk("rst_t_addr", t_addr, 0);
        @(negedge clk) rst_n = 1'b1;
        tick(); tick();
        // Single read of mtime low from p0
        p0_req = 1; p0_cmd = YCR1_MEM_CMD_RD; p0_width = WORD; p0_addr = 32'h08;
        tick();
        chk_acks("rd_c1", 1, 0);
        chk("rd_c1_t_req", 32'(t_req), 1);
        chk("rd_c1_t_addr", t_addr, 32'h08);
        p0_req = 0;
        tick();
        chk_acks("rd_c2", 0, 0);
        chk("rd_c2_t_req", 32'(t_req), 1);
        chk("rd_c2_t_ack", 32'(t_req_ack), 1);
        tick();
        chk("rd_c3_t_req", 32'(t_req), 0);
        chk_ports("rd_c3", NR, 0, NR, 0);
        tick();
        chk_ports("rd_c4", OK, 32'h0000_0123, NR, 0);
        tick();
        chk_ports("rd_c5", NR, 0, NR, 0);
        // Contention from a fresh reset: grants alternate p0, p1, p0, p1
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        p0_addr = 32'h08; p0_width = WORD; p0_cmd = YCR1_MEM_CMD_RD;
        p1_addr = 32'h08; p1_width = WORD; p1_cmd = YCR1_MEM_CMD_RD;
        p0_req = 1; p1_req = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_acks($sformatf("rr%0d", k), !k[0], k[0]);
            if (k[0]) p1_req = 0; else p0_req = 0;
            tick();
            if (k == 3) begin p0_req = 0; p1_req = 0; end
            else if (k[0]) p1_req = 1;
            else p0_req = 1;
            tick(); tick();
            if (k[0]) chk_ports($sformatf("rr%0d_c4", k), NR, 0, OK, 32'h0000_0123);
            else      chk_ports($sformatf("rr%0d_c4", k), OK, 32'h0000_0123, NR, 0);
        end
        tick();
        chk_acks("rr_idle", 0, 0);
        // Write then read back through p1
        p1_req = 1; p1_cmd = YCR1_MEM_CMD_WR; p1_width = WORD; p1_addr = 32'h10; p1_wdata = 32'h0000_0010;
        tick();
        chk_acks("wr_c1", 0, 1);
        chk("wr_c1_t_cmd", 32'(t_cmd), 1);
        chk("wr_c1_t_addr", t_addr, 32'h10);
        chk("wr_c1_t_wdata", t_wdata, 32'h0000_0010);
        p1_req = 0; p1_wdata = 32'hDEAD_BEEF;
        tick();
        chk("wr_c2_t_wdata", t_wdata, 32'h0000_0010);
        chk("wr_c2_t_req", 32'(t_req), 1);
        tick(); tick();
        chk_ports("wr_c4", NR, 0, OK, 0);
        p1_req = 1; p1_cmd = YCR1_MEM_CMD_RD;
        tick();
        chk_acks("rb_c1", 0, 1);
        chk("rb_c1_t_cmd", 32'(t_cmd), 0);
        p1_req = 0;
        tick(); tick(); tick();
        chk_ports("rb_c4", NR, 0, OK, 32'h0000_0010);
        // Reset while waiting in RESP, then a stale response after release
        p0_req = 1; p0_cmd = YCR1_MEM_CMD_RD; p0_width = BYTE; p0_addr = 32'h08;
        tick();
        chk_acks("mr_c1", 1, 0);
        p0_req = 0;
        tick(); tick();
        chk("mr_c3_t_req", 32'(t_req), 0);
        chk("mr_c3_t_addr", t_addr, 32'h08);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_rst_t_addr", t_addr, 0);
        chk("mr_rst_t_req", 32'(t_req), 0);
        chk_ports("mr_rst", NR, 0, NR, 0);
        @(negedge clk) rst_n = 1'b1;
        inj = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ports($sformatf("stale%0d", i), NR, 0, NR, 0);
            chk("stale_t_req", 32'(t_req), 0);
        end
        inj = 1'b0;
        // Unsupported BYTE access: timer never leaves NOTRDY
        p0_req = 1; p0_cmd = YCR1_MEM_CMD_RD; p0_width = BYTE; p0_addr = 32'h08;
        tick();
        chk_acks("hg_c1", 1, 0);
        p0_req = 0;
        tick();
        p1_req = 1; p1_cmd = YCR1_MEM_CMD_RD; p1_width = WORD; p1_addr = 32'h08;
`ifdef YCR1_TIMER_ARB_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            tick();
            chk_ports($sformatf("tmo_wait%0d", i), NR, 0, NR, 0);
            chk_acks("tmo_wait", 0, 0);
        end
        tick();
        chk_ports("tmo_err", ER, 0, NR, 0);
        tick();
        chk_acks("tmo_next", 0, 1);
        p1_req = 0;
        tick(); tick(); tick();
        chk_ports("tmo_p1", NR, 0, OK, 32'h0000_0123);
`else
        for (int i = 0; i < 120; i++) begin
            tick();
            chk_ports($sformatf("hang%0d", i), NR, 0, NR, 0);
            chk_acks("hang", 0, 0);
            chk("hang_t_req", 32'(t_req), 0);
        end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
